// File: rtl/ft_pkg.sv
// Shared types and constants for the FT2232H synchronous-FIFO receive path.
package ft_pkg;

  localparam int USB_DATA_WIDTH = 8;
  localparam int TURN_CYCLES    = 1;

  typedef enum logic [1:0] {
    IDLE,
    OE,
    READ,
    TURN
  } ft_rx_state_t;

endpackage

// File: rtl/ft_rx_buf.sv
// Receive FIFO with a registered output stage. A write into an empty FIFO
// lands directly in the output register, so data is visible one cycle later.
module ft_rx_buf
  import ft_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wr,
  input  logic [USB_DATA_WIDTH-1:0] i_wdata,
  input  logic                      i_ready,
  output logic [USB_DATA_WIDTH-1:0] o_data,
  output logic                      o_valid,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [USB_DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]             r_wptr;
  logic [AW-1:0]             r_rptr;
  logic [CW-1:0]             r_cnt;
  logic [USB_DATA_WIDTH-1:0] r_data;
  logic                      r_valid;

  logic w_out_free;
  logic w_mem_empty;
  logic w_bypass;
  logic w_load;
  logic w_push;

  assign w_out_free  = !r_valid || i_ready;
  assign w_mem_empty = (r_cnt == '0);
  assign w_bypass    = i_wr && w_mem_empty && w_out_free;
  assign w_load      = w_out_free && !w_mem_empty;
  assign w_push      = i_wr && !w_bypass;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_load) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_load);
      // Older stored bytes always leave before a new write may bypass.
      if (w_load) begin
        r_data  <= r_mem[r_rptr];
        r_valid <= 1'b1;
      end else if (w_bypass) begin
        r_data  <= i_wdata;
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are meaningful, and a reset here would block RAM mapping.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_count = r_cnt + CW'(r_valid);

endmodule

// File: rtl/ft_rx_ctrl.sv
// FT2232H synchronous FIFO read controller: paces RD#/OE# against buffer space,
// counts received bytes and checks an incrementing-counter test stream.
module ft_rx_ctrl
  import ft_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit CHECK_SEQ = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [USB_DATA_WIDTH-1:0] ft_data_i,
  input  logic                      ft_rxf_n_i,
  output logic                      ft_oe_n_o,
  output logic                      ft_rd_n_o,
  input  logic                      ft_suspend_n_i,
  output logic [USB_DATA_WIDTH-1:0] m_data_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [31:0]               byte_cnt_o,
  output logic [15:0]               err_cnt_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  ft_rx_state_t              r_state;
  logic                      r_oe_n;
  logic                      r_rd_n;
  logic [1:0]                r_turn_cnt;
  logic [31:0]               r_byte_cnt;
  logic [15:0]               r_err_cnt;
  logic                      r_seeded;
  logic [USB_DATA_WIDTH-1:0] r_exp;

  logic          w_xfer;
  logic          w_pop;
  logic          w_start;
  logic          w_stop;
  logic [CW-1:0] w_occ;
  logic [CW-1:0] w_occ_next;

  assign w_xfer     = !r_rd_n && !ft_rxf_n_i;
  assign w_pop      = m_valid_o && m_ready_i;
  assign w_occ_next = w_occ + CW'(w_xfer) - CW'(w_pop);
  assign w_start    = !ft_rxf_n_i && ft_suspend_n_i && (w_occ <= CW'(DEPTH - 3));
  // Stopping on post-edge occupancy means the byte landing on this edge is the last one.
  assign w_stop     = ft_rxf_n_i || !ft_suspend_n_i || (w_occ_next >= CW'(DEPTH - 2));

  ft_rx_buf #(.DEPTH(DEPTH)) u_buf (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_wr    (w_xfer),
    .i_wdata (ft_data_i),
    .i_ready (m_ready_i),
    .o_data  (m_data_o),
    .o_valid (m_valid_o),
    .o_count (w_occ)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_oe_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_turn_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_state <= OE;
          r_oe_n  <= 1'b0;
        end
        OE: begin
          r_state <= READ;
          r_rd_n  <= 1'b0;
        end
        READ: if (w_stop) begin
          r_state    <= TURN;
          r_rd_n     <= 1'b1;
          r_turn_cnt <= '0;
        end
        TURN: if (r_turn_cnt == 2'(TURN_CYCLES - 1)) begin
          r_state <= IDLE;
          r_oe_n  <= 1'b1;
        end else begin
          r_turn_cnt <= r_turn_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_byte_cnt <= '0;
      r_err_cnt  <= '0;
      r_seeded   <= 1'b0;
      r_exp      <= '0;
    end else if (w_xfer) begin
      r_byte_cnt <= r_byte_cnt + 1'b1;
      r_seeded   <= 1'b1;
      r_exp      <= ft_data_i + 8'd1;
      if (CHECK_SEQ && r_seeded && (ft_data_i != r_exp) && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign ft_oe_n_o  = r_oe_n;
  assign ft_rd_n_o  = r_rd_n;
  assign byte_cnt_o = r_byte_cnt;
  assign err_cnt_o  = r_err_cnt;

endmodule

// File: tb/tb_ft_rx_ctrl.sv
// Bench for ft_rx_ctrl: FT2232H host model, downstream sink and an in-order
// scoreboard, with per-cycle protocol invariants and scenario tasks.
module tb_ft_rx_ctrl;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  ft_data_i;
  logic        ft_rxf_n_i;
  logic        ft_oe_n_o;
  logic        ft_rd_n_o;
  logic        ft_suspend_n_i;
  logic [7:0]  m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] byte_cnt_o;
  logic [15:0] err_cnt_o;

  logic        ns_oe_n, ns_rd_n, ns_valid;
  logic [7:0]  ns_data;
  logic [31:0] ns_byte_cnt;
  logic [15:0] ns_err_cnt;

  always #5 clk_i = ~clk_i;

  ft_rx_ctrl #(.DEPTH(DEPTH), .CHECK_SEQ(1'b1)) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ft_data_i      (ft_data_i),
    .ft_rxf_n_i     (ft_rxf_n_i),
    .ft_oe_n_o      (ft_oe_n_o),
    .ft_rd_n_o      (ft_rd_n_o),
    .ft_suspend_n_i (ft_suspend_n_i),
    .m_data_o       (m_data_o),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .byte_cnt_o     (byte_cnt_o),
    .err_cnt_o      (err_cnt_o)
  );

  // Second instance with the checker disabled; only its error count is observed.
  ft_rx_ctrl #(.DEPTH(DEPTH), .CHECK_SEQ(1'b0)) u_dut_noseq (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ft_data_i      (ft_data_i),
    .ft_rxf_n_i     (ft_rxf_n_i),
    .ft_oe_n_o      (ns_oe_n),
    .ft_rd_n_o      (ns_rd_n),
    .ft_suspend_n_i (ft_suspend_n_i),
    .m_data_o       (ns_data),
    .m_valid_o      (ns_valid),
    .m_ready_i      (m_ready_i),
    .byte_cnt_o     (ns_byte_cnt),
    .err_cnt_o      (ns_err_cnt)
  );

  logic [7:0] host_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] xfer_log[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_xfer, n_cons, n_sent;
  int  oe_only;
  bit  prev_rd_n;
  bit  hold;

  function automatic int exp_errs();
    int e = 0;
    for (int i = 1; i < xfer_log.size(); i++)
      if (xfer_log[i] != 8'(xfer_log[i-1] + 8'd1)) e++;
    return (e > 65535) ? 65535 : e;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    xfer_log.delete();
    n_xfer    = 0;
    n_cons    = 0;
    oe_only   = 0;
    prev_rd_n = 1'b1;
  endtask

  // One clock: drive host lines, predict the edge, then update model and check.
  task automatic step();
    bit xfer, cons, held, in_rst, was_empty;
    logic [7:0] xbyte, cbyte, pdata, e;
    ft_rxf_n_i = (host_q.size() == 0) || hold;
    ft_data_i  = (host_q.size() != 0) ? host_q[0] : 8'h00;
    xfer      = (ft_rd_n_o === 1'b0) && (ft_rxf_n_i === 1'b0);
    xbyte     = ft_data_i;
    cons      = (m_valid_o === 1'b1) && (m_ready_i === 1'b1);
    cbyte     = m_data_o;
    held      = (m_valid_o === 1'b1) && (m_ready_i === 1'b0);
    pdata     = m_data_o;
    in_rst    = rst_i;
    was_empty = (exp_q.size() == 0);
    @(negedge clk_i);
    if (xfer) begin
      void'(host_q.pop_front());
      n_sent++;
    end
    if (in_rst) begin
      model_clear();
    end else begin
      if (cons) begin
        n_tests++;
        n_cons++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_spurious: got byte %h, expected none", cbyte);
        end else begin
          e = exp_q.pop_front();
          if (cbyte !== e) begin
            n_fail++;
            $display("FAIL sb_order: got %h, expected %h", cbyte, e);
          end
        end
      end
      if (xfer) begin
        exp_q.push_back(xbyte);
        xfer_log.push_back(xbyte);
        n_xfer++;
        if (was_empty) begin
          n_tests++;
          if (m_valid_o !== 1'b1 || m_data_o !== xbyte) begin
            n_fail++;
            $display("FAIL latency: got valid=%b data=%h, expected valid=1 data=%h",
                     m_valid_o, m_data_o, xbyte);
          end
        end
      end
      if (held) begin
        n_tests++;
        if (m_valid_o !== 1'b1 || m_data_o !== pdata) begin
          n_fail++;
          $display("FAIL stall_stable: got valid=%b data=%h, expected valid=1 data=%h",
                   m_valid_o, m_data_o, pdata);
        end
      end
      n_tests++;
      if (ft_rd_n_o === 1'b0 && ft_oe_n_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_without_oe: got oe_n=%b, expected 0", ft_oe_n_o);
      end
      n_tests++;
      if (exp_q.size() > DEPTH || (exp_q.size() >= DEPTH - 2 && ft_rd_n_o !== 1'b1)) begin
        n_fail++;
        $display("FAIL occupancy: got occ=%0d rd_n=%b, expected occ<=%0d and rd_n=1 at occ>=%0d",
                 exp_q.size(), ft_rd_n_o, DEPTH, DEPTH - 2);
      end
      if (ft_rd_n_o === 1'b0 && prev_rd_n) begin
        n_tests++;
        if (oe_only != 1) begin
          n_fail++;
          $display("FAIL oe_lead: got %0d OE-only cycles, expected 1", oe_only);
        end
      end
      oe_only   = (ft_oe_n_o === 1'b0 && ft_rd_n_o === 1'b1) ? oe_only + 1 : 0;
      prev_rd_n = (ft_rd_n_o !== 1'b0);
    end
    n_tests++;
    if (byte_cnt_o !== 32'(n_xfer)) begin
      n_fail++;
      $display("FAIL byte_cnt: got %0d, expected %0d", byte_cnt_o, n_xfer);
    end
    n_tests++;
    if (ns_err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL noseq_err: got %0d, expected 0", ns_err_cnt);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    hold  = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    host_q.delete();
    hold   = 1'b0;
    n_sent = 0;
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while ((host_q.size() != 0 || exp_q.size() != 0 || m_valid_o === 1'b1) && c < budget) begin
      step();
      c++;
    end
    n_tests++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d host + %0d buffered left, expected 0",
               name, host_q.size(), exp_q.size());
    end
  endtask

  task automatic wait_sent(input string name, input int target, input int budget);
    int c = 0;
    while (n_sent < target && c < budget) begin
      step();
      c++;
    end
    n_tests++;
    if (n_sent < target) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d sent, expected %0d", name, n_sent, target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 6;
    if (ft_oe_n_o !== 1'b1) begin n_fail++; $display("FAIL rst_oe_n: got %b, expected 1", ft_oe_n_o); end
    if (ft_rd_n_o !== 1'b1) begin n_fail++; $display("FAIL rst_rd_n: got %b, expected 1", ft_rd_n_o); end
    if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", m_valid_o); end
    if (m_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h, expected 00", m_data_o); end
    if (byte_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rst_byte_cnt: got %0d, expected 0", byte_cnt_o); end
    if (err_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d, expected 0", err_cnt_o); end
  endtask

  task automatic test_stream();
    do_reset();
    m_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) host_q.push_back(8'(i));
    drain("stream", 1200);
    n_tests += 3;
    if (n_cons != 256) begin n_fail++; $display("FAIL stream_count: got %0d, expected 256", n_cons); end
    if (byte_cnt_o !== 32'd256) begin n_fail++; $display("FAIL stream_byte_cnt: got %0d, expected 256", byte_cnt_o); end
    if (err_cnt_o !== 16'd0) begin n_fail++; $display("FAIL stream_err: got %0d, expected 0", err_cnt_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) host_q.push_back(8'(8'h40 + i));
    for (int i = 0; i < 30; i++) step();
    n_tests += 4;
    if (exp_q.size() != DEPTH - 2) begin n_fail++; $display("FAIL bp_occ: got %0d, expected %0d", exp_q.size(), DEPTH - 2); end
    if (ft_rd_n_o !== 1'b1) begin n_fail++; $display("FAIL bp_rd_n: got %b, expected 1", ft_rd_n_o); end
    if (host_q.size() != 20 - (DEPTH - 2)) begin n_fail++; $display("FAIL bp_pending: got %0d, expected %0d", host_q.size(), 20 - (DEPTH - 2)); end
    if (m_valid_o !== 1'b1 || m_data_o !== 8'h40) begin n_fail++; $display("FAIL bp_head: got valid=%b data=%h, expected 1/40", m_valid_o, m_data_o); end
    m_ready_i = 1'b1;
    drain("bp", 300);
    n_tests++;
    if (n_cons != 20) begin n_fail++; $display("FAIL bp_count: got %0d, expected 20", n_cons); end
  endtask

  task automatic test_rxf_pause();
    do_reset();
    m_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) host_q.push_back(8'(i));
    wait_sent("pause", 6, 40);
    hold = 1'b1;
    step();
    n_tests++;
    if (ft_rd_n_o !== 1'b1 || ft_oe_n_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_turn: got rd_n=%b oe_n=%b, expected 1/0", ft_rd_n_o, ft_oe_n_o);
    end
    step();
    n_tests++;
    if (ft_rd_n_o !== 1'b1 || ft_oe_n_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_idle: got rd_n=%b oe_n=%b, expected 1/1", ft_rd_n_o, ft_oe_n_o);
    end
    hold = 1'b0;
    drain("pause", 200);
    n_tests += 2;
    if (n_cons != 12) begin n_fail++; $display("FAIL pause_count: got %0d, expected 12", n_cons); end
    if (err_cnt_o !== 16'd0) begin n_fail++; $display("FAIL pause_err: got %0d, expected 0", err_cnt_o); end
  endtask

  task automatic test_seq_errors();
    logic [7:0] s1[4] = '{8'h10, 8'h11, 8'h13, 8'h14};
    logic [7:0] s2[5] = '{8'hFE, 8'hFF, 8'h00, 8'h05, 8'h06};
    do_reset();
    m_ready_i = 1'b1;
    foreach (s1[i]) host_q.push_back(s1[i]);
    drain("seq1", 100);
    n_tests++;
    if (err_cnt_o !== 16'd1) begin n_fail++; $display("FAIL seq_gap: got %0d, expected 1", err_cnt_o); end
    do_reset();
    for (int i = 0; i < 3; i++) host_q.push_back(s2[i]);
    drain("seq2", 100);
    n_tests++;
    if (err_cnt_o !== 16'd0) begin n_fail++; $display("FAIL seq_wrap: got %0d, expected 0", err_cnt_o); end
    for (int i = 3; i < 5; i++) host_q.push_back(s2[i]);
    drain("seq3", 100);
    n_tests++;
    if (err_cnt_o !== 16'd1) begin n_fail++; $display("FAIL seq_resync: got %0d, expected 1", err_cnt_o); end
  endtask

  task automatic test_suspend();
    int s;
    do_reset();
    m_ready_i      = 1'b1;
    ft_suspend_n_i = 1'b0;
    for (int i = 0; i < 8; i++) host_q.push_back(8'(8'h80 + i));
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if (ft_oe_n_o !== 1'b1 || ft_rd_n_o !== 1'b1) begin
        n_fail++;
        $display("FAIL susp_idle: got oe_n=%b rd_n=%b, expected 1/1", ft_oe_n_o, ft_rd_n_o);
      end
    end
    ft_suspend_n_i = 1'b1;
    wait_sent("susp", 3, 20);
    ft_suspend_n_i = 1'b0;
    step();
    n_tests++;
    if (ft_rd_n_o !== 1'b1) begin n_fail++; $display("FAIL susp_stop: got rd_n=%b, expected 1", ft_rd_n_o); end
    s = n_sent;
    for (int i = 0; i < 5; i++) step();
    n_tests++;
    if (n_sent != s) begin n_fail++; $display("FAIL susp_hold: got %0d sent, expected %0d", n_sent, s); end
    ft_suspend_n_i = 1'b1;
    drain("susp", 200);
    n_tests++;
    if (n_cons != 8) begin n_fail++; $display("FAIL susp_count: got %0d, expected 8", n_cons); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) host_q.push_back(8'(8'h20 + i));
    wait_sent("rstmid", 3, 40);
    rst_i = 1'b1;
    step();
    n_tests += 5;
    if (ft_rd_n_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_rd_n: got %b, expected 1", ft_rd_n_o); end
    if (ft_oe_n_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_oe_n: got %b, expected 1", ft_oe_n_o); end
    if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, expected 0", m_valid_o); end
    if (byte_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rstmid_byte_cnt: got %0d, expected 0", byte_cnt_o); end
    if (err_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rstmid_err: got %0d, expected 0", err_cnt_o); end
    rst_i = 1'b0;
    host_q.delete();
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_random();
    logic [7:0] nxt = 8'h00;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      while (host_q.size() < 4) begin
        nxt = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'(nxt + 8'd1);
        host_q.push_back(nxt);
      end
      m_ready_i = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) hold = !hold;
      if ($urandom_range(0, 49) == 0) ft_suspend_n_i = !ft_suspend_n_i;
      step();
    end
    hold           = 1'b0;
    ft_suspend_n_i = 1'b1;
    m_ready_i      = 1'b1;
    drain("rand", 300);
    n_tests += 3;
    if (err_cnt_o !== 16'(exp_errs())) begin n_fail++; $display("FAIL rand_err: got %0d, expected %0d", err_cnt_o, exp_errs()); end
    if (byte_cnt_o !== 32'(n_xfer)) begin n_fail++; $display("FAIL rand_byte_cnt: got %0d, expected %0d", byte_cnt_o, n_xfer); end
    if (n_cons != n_xfer) begin n_fail++; $display("FAIL rand_delivered: got %0d, expected %0d", n_cons, n_xfer); end
  endtask

  initial begin
    rst_i          = 1'b1;
    ft_data_i      = 8'h00;
    ft_rxf_n_i     = 1'b1;
    ft_suspend_n_i = 1'b1;
    m_ready_i      = 1'b1;
    hold           = 1'b1;
    n_sent         = 0;
    model_clear();
    test_reset();
    test_stream();
    test_backpressure();
    test_rxf_pause();
    test_seq_errors();
    test_suspend();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ft_rx_ctrl.md
FT_RX_CTRL -- requirements
Module: ft_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the internal receive buffer depth in bytes; it must be a power of two and at least 4.
REQ-002 SHALL have parameter CHECK_SEQ, default 1, which enables the incrementing-counter sequence checker.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock, the FT2232H 60 MHz CLKOUT.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port ft_data_i, input, 8 bits: FT2232H FIFO data bus, input half; tristate control lives in the top level.
REQ-006 SHALL have port ft_rxf_n_i, input, 1 bit: low when the FT2232H holds readable data.
REQ-007 SHALL have port ft_oe_n_o, output, 1 bit: low drives the FT2232H data onto the bus; the top level tristates its own driver while this is low.
REQ-008 SHALL have port ft_rd_n_o, output, 1 bit: low requests one byte per clock.
REQ-009 SHALL have port ft_suspend_n_i, input, 1 bit: low while USB is suspended.
REQ-010 SHALL have port m_data_o, output, 8 bits: downstream byte.
REQ-011 SHALL have port m_valid_o, output, 1 bit: m_data_o holds a valid byte.
REQ-012 SHALL have port m_ready_i, input, 1 bit: downstream accepts the byte.
REQ-013 SHALL have port byte_cnt_o, output, 32 bits: total bytes transferred from the FT2232H; wraps on overflow.
REQ-014 SHALL have port err_cnt_o, output, 16 bits: sequence mismatches; saturates at 16'hFFFF.

Function
REQ-015 SHALL run a state machine with states IDLE, OE, READ and TURN; all FT outputs are registered.
REQ-016 IDLE -> OE: when ft_rxf_n_i=0, ft_suspend_n_i=1 and buffer free space >= 3; in OE, ft_oe_n_o=0 and ft_rd_n_o=1.
REQ-017 OE -> READ after exactly 1 cycle; in READ, ft_oe_n_o=0 and ft_rd_n_o=0.
REQ-018 A byte SHALL be transferred on any posedge where the registered ft_rd_n_o=0 and ft_rxf_n_i=0; ft_data_i is written into the buffer on that edge and byte_cnt_o increments.
REQ-019 READ -> TURN on any of: ft_rxf_n_i=1; ft_suspend_n_i=0; buffer occupancy after the current edge >= DEPTH-2. In TURN, ft_rd_n_o=1 and ft_oe_n_o=0 for 1 cycle, then ft_oe_n_o=1 and the FSM enters IDLE.
REQ-020 The buffer SHALL never overflow, including the byte in flight during the cycle rd_n deasserts; no transferred byte may be dropped.
REQ-021 The downstream port SHALL use a valid/ready handshake: a byte transfers when m_valid_o=1 and m_ready_i=1; m_data_o stays stable while m_valid_o=1 and m_ready_i=0.
REQ-022 Latency from the FT transfer edge to m_valid_o SHALL be 1 cycle when the buffer was empty.
REQ-023 A simultaneous buffer write and read SHALL leave occupancy unchanged; reading an empty buffer is impossible by construction.
REQ-024 Checker (CHECK_SEQ=1): the first byte after reset seeds the expected value, which becomes byte+1; each later byte is compared against the expected value.
REQ-025 On a checker mismatch, err_cnt_o increments (saturating) and the expected value resyncs to byte+1.
REQ-026 The checker expected value SHALL wrap 8'hFF -> 8'h00 without error.
REQ-027 With CHECK_SEQ=0, err_cnt_o SHALL be constant 0.

Reset
REQ-028 On rst_i=1 at a posedge: state=IDLE, ft_oe_n_o=1, ft_rd_n_o=1, m_valid_o=0, m_data_o=0, buffer empty, byte_cnt_o=0, err_cnt_o=0, checker unseeded.
REQ-029 Reset asserted mid-READ SHALL release rd_n and oe_n on the next edge; bytes already buffered are discarded.

Structure
REQ-030 Package ft_pkg SHALL hold USB_DATA_WIDTH=8, the ft_rx_state_t enum and the TURN length constant.
REQ-031 The buffer SHALL be a sub-module ft_rx_buf: a synchronous FIFO with count output, write-first-read and registered output.

Verification
REQ-032 Host model streams 0x00..0xFF, m_ready_i=1 -> 256 bytes out in order, byte_cnt_o=256, err_cnt_o=0, exactly 1 OE-only cycle before the first rd_n low.
REQ-033 m_ready_i=0 with DEPTH=8 while 20 bytes are pending -> rd_n high once occupancy reaches 6, occupancy never exceeds 8, all 20 bytes delivered after ready=1.
REQ-034 rxf_n rises mid-burst after byte 0x05 -> TURN 1 cycle, then IDLE; resume when rxf_n=0 yields 0x06 next with no duplicate.
REQ-035 Stream 0x10,0x11,0x13,0x14 -> err_cnt_o=1; 0xFE,0xFF,0x00 -> no error.
REQ-036 rst_i pulsed during READ -> next edge rd_n=1, oe_n=1, m_valid_o=0, counters 0.
REQ-037 ft_suspend_n_i=0 with rxf_n=0 -> no read is initiated; if asserted during READ, TURN follows within 1 cycle.
